ball_move_ctrl: RTL

- Sequences one ball step per movement tick in the labyrinth game.
- Latches the tilt direction and probes the maze map through a request/acknowledge read port.
- On a diagonal blocked by a wall, retries the single-axis moves so the ball slides along the wall.
- Commits the new position and flags goal arrival; sits between the accelerometer direction decode/tick generator and the map ROM and display logic.

---
 rtl/ball_move_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ball_move_ctrl.sv
// One ball step per movement tick: decode tilt, probe the maze map per candidate cell,
// slide along walls on blocked diagonals, commit the move and track goal arrival.
module ball_move_ctrl #(
  parameter int unsigned COORD_W     = 5,
  parameter int unsigned MAP_W       = 2,
  parameter int unsigned WALL_CODE   = 2,
  parameter int unsigned GOAL_CODE   = 3,
  parameter int unsigned MAX_X       = 31,
  parameter int unsigned MAX_Y       = 31,
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 1,
  parameter int unsigned MAP_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               move_tick,
  input  logic               x_increment,
  input  logic               x_decriment,
  input  logic               y_increment,
  input  logic               y_decriment,
  output logic               map_req,
  output logic [COORD_W-1:0] map_addr_x,
  output logic [COORD_W-1:0] map_addr_y,
  input  logic               map_ack,
  input  logic [MAP_W-1:0]   map_value,
  output logic [COORD_W-1:0] x_loc,
  output logic [COORD_W-1:0] y_loc,
  output logic               moved,
  output logic               blocked,
  output logic               goal_reached,
  output logic               busy
);

  localparam int unsigned TmoW = $clog2(MAP_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSelect, StReq} state_e;

  state_e            state_q;
  logic              dx_nz_q, dx_neg_q, dy_nz_q, dy_neg_q;
  logic [1:0]        idx_q;
  logic [TmoW-1:0]   tmo_q;

  logic              dx_nz, dy_nz;
  logic              diag, use_x, use_y, past, oob;
  logic [1:0]        n_cand;
  logic [COORD_W-1:0] cand_x, cand_y;

  assign dx_nz = x_increment ^ x_decriment;
  assign dy_nz = y_increment ^ y_decriment;
  assign busy  = (state_q != StIdle);

  // Diagonal order: both axes, then x only, then y only.
  always_comb begin
    diag   = dx_nz_q & dy_nz_q;
    n_cand = diag ? 2'd3 : 2'd1;
    use_x  = dx_nz_q & (~diag | (idx_q != 2'd2));
    use_y  = dy_nz_q & (~diag | (idx_q != 2'd1));
    past   = (idx_q >= n_cand);
    oob    = (use_x & (dx_neg_q ? (x_loc == '0) : (x_loc == COORD_W'(MAX_X)))) |
             (use_y & (dy_neg_q ? (y_loc == '0) : (y_loc == COORD_W'(MAX_Y))));
    cand_x = x_loc;
    cand_y = y_loc;
    if (use_x) cand_x = dx_neg_q ? x_loc - COORD_W'(1) : x_loc + COORD_W'(1);
    if (use_y) cand_y = dy_neg_q ? y_loc - COORD_W'(1) : y_loc + COORD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q      <= StIdle;
      x_loc        <= COORD_W'(START_X);
      y_loc        <= COORD_W'(START_Y);
      map_req      <= 1'b0;
      map_addr_x   <= '0;
      map_addr_y   <= '0;
      moved        <= 1'b0;
      blocked      <= 1'b0;
      goal_reached <= 1'b0;
      idx_q        <= '0;
      tmo_q        <= '0;
      dx_nz_q      <= 1'b0;
      dx_neg_q     <= 1'b0;
      dy_nz_q      <= 1'b0;
      dy_neg_q     <= 1'b0;
    end else begin
      moved   <= 1'b0;
      blocked <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (move_tick && (dx_nz || dy_nz) && !goal_reached) begin
            dx_nz_q  <= dx_nz;
            dx_neg_q <= x_decriment;
            dy_nz_q  <= dy_nz;
            dy_neg_q <= y_decriment;
            idx_q    <= '0;
            state_q  <= StSelect;
          end
        end
        StSelect: begin
          if (past) begin
            blocked <= 1'b1;
            state_q <= StIdle;
          end else if (oob) begin
            // Skipping the last candidate reports blocked without an extra SELECT cycle.
            if (idx_q + 2'd1 >= n_cand) begin
              blocked <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            map_addr_x <= cand_x;
            map_addr_y <= cand_y;
            map_req    <= 1'b1;
            tmo_q      <= '0;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (map_ack) begin
            map_req <= 1'b0;
            if (map_value == MAP_W'(WALL_CODE)) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StSelect;
            end else begin
              x_loc   <= map_addr_x;
              y_loc   <= map_addr_y;
              moved   <= 1'b1;
              if (map_value == MAP_W'(GOAL_CODE)) goal_reached <= 1'b1;
              state_q <= StIdle;
            end
          end else if (tmo_q == TmoW'(MAP_TIMEOUT - 1)) begin
            // A silent map is treated as a wall.
            map_req <= 1'b0;
            idx_q   <= idx_q + 2'd1;
            state_q <= StSelect;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
